// File: rtl/multi_clock_generator.sv
// Multi-channel programmable clock divider: per-channel tick strobe and 50 % divided clock,
// plus a display-scan counter advanced by the tick of one selected channel.
module multi_clock_generator #(
    parameter int                        NUM_CH       = 3,
    parameter int                        DIV_W        = 27,
    parameter logic [NUM_CH*DIV_W-1:0]   DEFAULT_DIVS = {27'd500000, 27'd50000000, 27'd100000},
    parameter int                        SCAN_CH      = 0,
    parameter int                        CTL_W        = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clear,
    input  logic              div_wr,
    input  logic [2:0]        div_sel,
    input  logic [DIV_W-1:0]  div_data,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out,
    output logic [CTL_W-1:0]  clk_ctl
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DIV_W-1:0] div_q;
        logic [DIV_W-1:0] cnt_q;
        logic             tick_q;
        logic             lvl_q;
        logic             wr_hit;

        // Selects beyond NUM_CH never match any channel, so such writes are dropped.
        assign wr_hit     = div_wr && (div_sel == 3'(g));
        assign tick[g]    = tick_q;
        assign clk_out[g] = lvl_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                div_q  <= DEFAULT_DIVS[g*DIV_W +: DIV_W];
                cnt_q  <= '0;
                tick_q <= 1'b0;
                lvl_q  <= 1'b0;
            end else begin
                if (wr_hit) begin
                    div_q <= div_data;
                end
                if (clear) begin
                    cnt_q  <= '0;
                    tick_q <= 1'b0;
                    lvl_q  <= 1'b0;
                end else if (wr_hit) begin
                    // A write restarts the period and suppresses a coincident terminal tick.
                    cnt_q  <= '0;
                    tick_q <= 1'b0;
                end else if (!en) begin
                    tick_q <= 1'b0;
                end else if (cnt_q == div_q) begin
                    cnt_q  <= '0;
                    tick_q <= 1'b1;
                    lvl_q  <= ~lvl_q;
                end else begin
                    cnt_q  <= cnt_q + DIV_W'(1);
                    tick_q <= 1'b0;
                end
            end
        end
    end

    // Scan counter follows the registered strobe, so it steps one cycle after the tick.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            clk_ctl <= '0;
        end else if (en && tick[SCAN_CH]) begin
            clk_ctl <= clk_ctl + CTL_W'(1);
        end
    end

endmodule
